// File: rtl/sound_voice_mixer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sound_voice_mixer                                          |
// | Description : Per-channel pulse/noise/sawtooth voices, summed to a PCM   |
// |               sample and driven out as 1-bit PWM.                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sound_voice_mixer #(
    parameter int NCH = 4
) (
    input  logic                      baseclk,
    input  logic                      asyncrst_n,
    input  logic [NCH*3-1:0]          octave,
    input  logic [NCH*4-1:0]          note,
    input  logic [NCH*4-1:0]          duty,
    input  logic [NCH*2-1:0]          mode,
    output logic [4+$clog2(NCH)-1:0]  pcm_out,
    output logic                      pcm_valid,
    output logic                      pwm_out
);

    localparam int SUMW = 4 + $clog2(NCH);

    localparam logic [1:0] c_MODE_MUTE  = 2'b00;
    localparam logic [1:0] c_MODE_PULSE = 2'b01;
    localparam logic [1:0] c_MODE_NOISE = 2'b10;
    localparam logic [1:0] c_MODE_SAW   = 2'b11;

    // Octave-0 clocks per 1/16 waveform step; rests never reach the divider.
    function automatic logic [15:0] f_step_rom(input logic [3:0] n);
        case (n)
            4'd0:    f_step_rom = 16'd47779;
            4'd1:    f_step_rom = 16'd45096;
            4'd2:    f_step_rom = 16'd42566;
            4'd3:    f_step_rom = 16'd40176;
            4'd4:    f_step_rom = 16'd37922;
            4'd5:    f_step_rom = 16'd35793;
            4'd6:    f_step_rom = 16'd33785;
            4'd7:    f_step_rom = 16'd31888;
            4'd8:    f_step_rom = 16'd30098;
            4'd9:    f_step_rom = 16'd28409;
            4'd10:   f_step_rom = 16'd26815;
            4'd11:   f_step_rom = 16'd25310;
            default: f_step_rom = 16'd0;
        endcase
    endfunction

    logic [NCH*4-1:0] w_amp_bus;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [2:0]  w_oct;
            logic [3:0]  w_note;
            logic [3:0]  w_duty;
            logic [1:0]  w_mode;
            logic [15:0] w_lim;
            logic        w_active;
            logic        w_wrap;
            logic [3:0]  w_amp_next;
            logic [15:0] r_div;
            logic [3:0]  r_step;
            logic [14:0] r_lfsr;
            logic [3:0]  r_amp;

            assign w_oct    = octave[gi*3 +: 3];
            assign w_note   = note[gi*4 +: 4];
            assign w_duty   = duty[gi*4 +: 4];
            assign w_mode   = mode[gi*2 +: 2];
            assign w_lim    = f_step_rom(w_note) >> w_oct;
            assign w_active = (w_mode != c_MODE_MUTE) && (w_note < 4'd12);
            // >= rather than == so a shrinking limit wraps at once instead of running to 65535.
            assign w_wrap   = (r_div >= (w_lim - 16'd1));

            always_comb begin
                w_amp_next = 4'd0;
                case (w_mode)
                    c_MODE_PULSE: w_amp_next = (r_step < w_duty) ? 4'hF : 4'h0;
                    c_MODE_NOISE: w_amp_next = {4{r_lfsr[0]}};
                    c_MODE_SAW:   w_amp_next = r_step;
                    default:      w_amp_next = 4'd0;
                endcase
            end

            always_ff @(posedge baseclk or negedge asyncrst_n) begin
                if (!asyncrst_n) begin
                    r_div  <= 16'd0;
                    r_step <= 4'd0;
                    r_lfsr <= 15'h0001;
                    r_amp  <= 4'd0;
                end else if (!w_active) begin
                    r_div  <= 16'd0;
                    r_step <= 4'd0;
                    r_amp  <= 4'd0;
                end else begin
                    r_amp <= w_amp_next;
                    if (w_wrap) begin
                        r_div  <= 16'd0;
                        r_step <= r_step + 4'd1;
                        if (w_mode == c_MODE_NOISE) begin
                            r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
                        end
                    end else begin
                        r_div <= r_div + 16'd1;
                    end
                end
            end

            assign w_amp_bus[gi*4 +: 4] = r_amp;
        end
    endgenerate

    logic [SUMW-1:0] w_sum;
    logic [SUMW-1:0] r_sum;
    logic [SUMW-1:0] r_pcnt;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NCH; i++) begin
            w_sum = w_sum + SUMW'(w_amp_bus[i*4 +: 4]);
        end
    end

    always_ff @(posedge baseclk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            r_sum     <= '0;
            r_pcnt    <= '0;
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
            pwm_out   <= 1'b0;
        end else begin
            r_sum   <= w_sum;
            r_pcnt  <= r_pcnt + 1'b1;
            pwm_out <= (r_pcnt < pcm_out);
            if (r_pcnt == {SUMW{1'b1}}) begin
                pcm_out   <= r_sum;
                pcm_valid <= 1'b1;
            end else begin
                pcm_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sound_voice_mixer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sound_voice_mixer                                       |
// | Description : Directed stimulus with a cycle model feeding a PCM queue.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sound_voice_mixer;

    localparam int NCH  = 4;
    localparam int SUMW = 6;

    logic              baseclk = 1'b0;
    logic              asyncrst_n;
    logic [NCH*3-1:0]  octave;
    logic [NCH*4-1:0]  note;
    logic [NCH*4-1:0]  duty;
    logic [NCH*2-1:0]  mode;
    logic [SUMW-1:0]   pcm_out;
    logic              pcm_valid;
    logic              pwm_out;

    always #20 baseclk = ~baseclk;

    sound_voice_mixer #(.NCH(NCH)) u_dut (
        .baseclk    (baseclk),
        .asyncrst_n (asyncrst_n),
        .octave     (octave),
        .note       (note),
        .duty       (duty),
        .mode       (mode),
        .pcm_out    (pcm_out),
        .pcm_valid  (pcm_valid),
        .pwm_out    (pwm_out)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int c_rom[12] = '{47779, 45096, 42566, 40176, 37922, 35793,
                      33785, 31888, 30098, 28409, 26815, 25310};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input int m, input int o, input int n, input int d);
        logic [31:0] v_m, v_o, v_n, v_d;
        v_m = m; v_o = o; v_n = n; v_d = d;
        mode[ch*2 +: 2]   = v_m[1:0];
        octave[ch*3 +: 3] = v_o[2:0];
        note[ch*4 +: 4]   = v_n[3:0];
        duty[ch*4 +: 4]   = v_d[3:0];
    endtask

    // Reference model of the voices, mixer and PWM; expected samples go to r_sb.
    int          m_div[NCH];
    int          m_step[NCH];
    int          m_amp[NCH];
    logic [14:0] m_lfsr[NCH];
    int          m_sum, m_pcnt, m_pcm;
    bit          m_pwm, m_valid;
    int          r_sb[$];

    always @(posedge baseclk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_div[c] = 0; m_step[c] = 0; m_amp[c] = 0; m_lfsr[c] = 15'h0001;
            end
            m_sum = 0; m_pcnt = 0; m_pcm = 0; m_pwm = 0; m_valid = 0;
            r_sb.delete();
        end else begin
            int nsum;
            nsum = 0;
            for (int c = 0; c < NCH; c++) nsum += m_amp[c];
            m_pwm   = (m_pcnt < m_pcm);
            m_valid = (m_pcnt == 63);
            if (m_valid) begin
                m_pcm = m_sum;
                r_sb.push_back(m_sum);
            end
            m_pcnt = (m_pcnt + 1) % 64;
            m_sum  = nsum;
            for (int c = 0; c < NCH; c++) begin
                int md, nt, oc, dt, lim;
                md = int'(mode[c*2 +: 2]);
                nt = int'(note[c*4 +: 4]);
                oc = int'(octave[c*3 +: 3]);
                dt = int'(duty[c*4 +: 4]);
                if (md == 0 || nt >= 12) begin
                    m_div[c] = 0; m_step[c] = 0; m_amp[c] = 0;
                end else begin
                    case (md)
                        1:       m_amp[c] = (m_step[c] < dt) ? 15 : 0;
                        2:       m_amp[c] = m_lfsr[c][0] ? 15 : 0;
                        default: m_amp[c] = m_step[c];
                    endcase
                    lim = c_rom[nt] >> oc;
                    if (m_div[c] >= lim - 1) begin
                        m_div[c]  = 0;
                        m_step[c] = (m_step[c] + 1) % 16;
                        if (md == 2) m_lfsr[c] = {m_lfsr[c][13:0], m_lfsr[c][14] ^ m_lfsr[c][13]};
                    end else begin
                        m_div[c] = m_div[c] + 1;
                    end
                end
            end
        end
    end

    always @(negedge baseclk) begin
        if (asyncrst_n === 1'b1) begin
            check("pwm_out", pwm_out, m_pwm);
            check("pcm_valid", pcm_valid, m_valid);
            if (pcm_valid === 1'b1) begin
                if (r_sb.size() == 0) check("sb_underflow", r_sb.size(), 1);
                else                  check("pcm_out", pcm_out, r_sb.pop_front());
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge baseclk);
    endtask

    task automatic first_valid_latency(input string tag);
        int cnt;
        cnt = 0;
        while (cnt < 200) begin
            @(negedge baseclk);
            cnt++;
            if (pcm_valid === 1'b1) break;
        end
        check(tag, cnt, 64);
    endtask

    initial begin
        int cnt, hi;
        bit saw_hi, saw_lo, saw_wrap;
        asyncrst_n = 1'b0;
        octave = '0; note = '0; duty = '0; mode = '0;
        run(3);
        check("rst_pcm_out", pcm_out, 0);
        check("rst_pcm_valid", pcm_valid, 0);
        check("rst_pwm_out", pwm_out, 0);

        // All muted: silence and a valid strobe every 64 clocks.
        #5 asyncrst_n = 1'b1;
        first_valid_latency("first_valid");
        cnt = 0;
        do begin @(negedge baseclk); cnt++; end while (pcm_valid !== 1'b1 && cnt < 200);
        check("valid_gap", cnt, 64);
        hi = 0;
        repeat (128) begin @(negedge baseclk); if (pwm_out === 1'b1) hi++; end
        check("mute_pwm_high", hi, 0);

        // Pulse, duty 8, lim 221.
        set_ch(0, 1, 7, 9, 8);
        saw_hi = 0; saw_lo = 0;
        repeat (7200) begin
            @(negedge baseclk);
            if (pcm_valid && pcm_out == 15) saw_hi = 1;
            if (pcm_valid && pcm_out == 0)  saw_lo = 1;
        end
        check("pulse_saw_hi", saw_hi, 1);
        check("pulse_saw_lo", saw_lo, 1);

        // Sawtooth, lim 373, starting from a cleared step.
        set_ch(0, 0, 0, 0, 0);
        run(4);
        set_ch(0, 3, 7, 0, 0);
        saw_hi = 0; saw_wrap = 0;
        repeat (6600) begin
            @(negedge baseclk);
            if (pcm_valid && pcm_out == 15) saw_hi = 1;
            if (pcm_valid && saw_hi && pcm_out == 0) saw_wrap = 1;
        end
        check("saw_reach_15", saw_hi, 1);
        check("saw_wrap_0", saw_wrap, 1);

        // Asynchronous reset in the middle of a tone.
        @(negedge baseclk);
        #5 asyncrst_n = 1'b0;
        #1;
        check("midrst_pcm_out", pcm_out, 0);
        check("midrst_pcm_valid", pcm_valid, 0);
        check("midrst_pwm_out", pwm_out, 0);
        run(2);
        #5 asyncrst_n = 1'b1;
        first_valid_latency("midrst_first_valid");

        // All four channels full-duty pulse: 60 of every 64 PWM clocks high.
        for (int c = 0; c < NCH; c++) set_ch(c, 1, 0, 0, 15);
        cnt = 0;
        while (pcm_out !== 6'd60 && cnt < 300) begin @(negedge baseclk); cnt++; end
        check("all_pulse_pcm", pcm_out, 60);
        @(negedge baseclk);
        hi = 0;
        repeat (64) begin @(negedge baseclk); if (pwm_out === 1'b1) hi++; end
        check("all_pulse_pwm_high", hi, 60);

        // Noise on ch1, lim 197.
        for (int c = 0; c < NCH; c++) set_ch(c, 0, 0, 0, 0);
        run(4);
        set_ch(1, 2, 7, 11, 0);
        saw_hi = 0; saw_lo = 0;
        repeat (4000) begin
            @(negedge baseclk);
            if (pcm_valid && pcm_out == 15) saw_hi = 1;
            if (pcm_valid && pcm_out == 0)  saw_lo = 1;
        end
        check("noise_saw_hi", saw_hi, 1);
        check("noise_saw_lo", saw_lo, 1);
        set_ch(1, 0, 0, 0, 0);

        // Rest mid-tone, then resume.
        set_ch(0, 1, 7, 9, 8);
        run(1000);
        set_ch(0, 1, 7, 12, 8);
        run(130);
        check("rest_pcm_zero", pcm_out, 0);
        set_ch(0, 1, 7, 9, 8);
        run(4000);

        // Shrinking limit below the running divider.
        set_ch(0, 0, 0, 0, 0);
        run(4);
        set_ch(0, 3, 0, 0, 0);
        run(3000);
        set_ch(0, 3, 7, 0, 0);
        saw_hi = 0;
        repeat (6200) begin
            @(negedge baseclk);
            if (pcm_valid && pcm_out == 15) saw_hi = 1;
        end
        check("shrink_reach_15", saw_hi, 1);
        check("sb_drained", r_sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
